// File: rtl/iob_wtb_mem.sv
`default_nettype none
// ============================================================================
//  Module      : iob_wtb_mem
//  Description : IOb-native slave memory with a posted-write buffer (WTB).
//                Writes are queued in a FIFO and drained one per cycle into
//                a single-port RAM. Reads are pipelined (RD_LAT cycles) and
//                are only accepted once every posted write has drained.
//  Revision    : 1.0 - initial release
// ============================================================================
module iob_wtb_mem #(
  parameter int DATA_W     = 256,
  parameter int ADDR_W     = 19,
  parameter int MEM_ADDR_W = 10,
  parameter int WTB_LOG2   = 2,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  input  logic                  iob_valid_i,
  input  logic [ADDR_W-1:0]     iob_addr_i,
  input  logic [DATA_W-1:0]     iob_wdata_i,
  input  logic [DATA_W/8-1:0]   iob_wstrb_i,
  output logic [DATA_W-1:0]     iob_rdata_o,
  output logic                  iob_rvalid_o,
  output logic                  iob_ready_o,
  input  logic                  invalidate_i,
  output logic                  invalidate_o,
  input  logic                  wtb_empty_i,
  output logic                  wtb_empty_o,
  output logic [WTB_LOG2:0]     wtb_level_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int DEPTH  = 2 ** WTB_LOG2;
  localparam int WORDS  = 2 ** MEM_ADDR_W;
  // Level value meaning "every WTB slot occupied".
  localparam logic [WTB_LOG2:0] FULL_LVL = {1'b1, {WTB_LOG2{1'b0}}};

  // Posted-write FIFO storage (not reset: only entries below level are live).
  logic [MEM_ADDR_W-1:0] fifo_addr_q [DEPTH];
  logic [DATA_W-1:0]     fifo_data_q [DEPTH];
  logic [STRB_W-1:0]     fifo_strb_q [DEPTH];

  logic [WTB_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [WTB_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [WTB_LOG2:0]     level_q, level_d;

  logic [DATA_W-1:0]     mem [WORDS];

  // Read pipeline: stage 0 captures RAM data at the accept edge.
  logic [RD_LAT-1:0]     rv_q;
  logic [DATA_W-1:0]     rd_q [RD_LAT];

  logic                  is_write;
  logic                  ready;
  logic                  push;
  logic                  pop;
  logic                  rd_acc;
  logic [MEM_ADDR_W-1:0] mem_addr;

  // Upper address bits alias onto the same physical word.
  logic                  unused_addr_hi;
  assign unused_addr_hi = ^iob_addr_i[ADDR_W-1:MEM_ADDR_W];
  assign mem_addr       = iob_addr_i[MEM_ADDR_W-1:0];

  // Handshake decode and FIFO pointer/level next-state.
  always_comb begin
    is_write = |iob_wstrb_i;
    // Reads wait for an empty WTB, so they can never overtake a posted write
    // and never collide with a drain on the single RAM port.
    ready    = is_write ? (level_q != FULL_LVL) : (level_q == '0);
    push     = iob_valid_i & ready & is_write;
    rd_acc   = iob_valid_i & ready & ~is_write;
    pop      = (level_q != '0);
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // FIFO pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Capture accepted writes into the FIFO slot at the write pointer.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= mem_addr;
      fifo_data_q[wr_ptr_q] <= iob_wdata_i;
      fifo_strb_q[wr_ptr_q] <= iob_wstrb_i;
    end
  end

  // Drain the FIFO head into the RAM with a byte-lane mask.
  always_ff @(posedge clk_i) begin
    if (pop) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (fifo_strb_q[rd_ptr_q][b]) begin
          mem[fifo_addr_q[rd_ptr_q]][b*8 +: 8] <= fifo_data_q[rd_ptr_q][b*8 +: 8];
        end
      end
    end
  end

  // Read pipeline; data stages only advance with a valid token so the
  // last stage holds rdata between rvalid pulses.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      rv_q <= '0;
      for (int k = 0; k < RD_LAT; k++) begin
        rd_q[k] <= '0;
      end
    end else begin
      rv_q[0] <= rd_acc;
      if (rd_acc) begin
        rd_q[0] <= mem[mem_addr];
      end
      for (int k = 1; k < RD_LAT; k++) begin
        rv_q[k] <= rv_q[k-1];
        if (rv_q[k-1]) begin
          rd_q[k] <= rd_q[k-1];
        end
      end
    end
  end

  assign iob_ready_o  = ready;
  assign iob_rdata_o  = rd_q[RD_LAT-1];
  assign iob_rvalid_o = rv_q[RD_LAT-1];
  assign invalidate_o = invalidate_i;
  assign wtb_empty_o  = wtb_empty_i & (level_q == '0);
  assign wtb_level_o  = level_q;

endmodule
`default_nettype wire

// File: tb/tb_iob_wtb_mem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iob_wtb_mem
//  Description : Self-checking bench for iob_wtb_mem. Two instances share the
//                same stimulus: A uses default parameters, B uses a 2-entry
//                WTB and a 3-cycle read latency. Read results are checked
//                against a model-memory scoreboard per instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_iob_wtb_mem;

  typedef struct {
    logic [255:0] data;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         arst_n;
  logic         valid;
  logic [18:0]  addr;
  logic [255:0] wdata;
  logic [31:0]  wstrb;
  logic         inv_i;
  logic         wte_i;

  logic [255:0] rdata_a, rdata_b;
  logic         rvalid_a, rvalid_b, ready_a, ready_b;
  logic         inv_a, inv_b, wte_a, wte_b;
  logic [2:0]   level_a;
  logic [1:0]   level_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  exp_t         qa[$];
  exp_t         qb[$];
  logic [255:0] model_mem [logic [9:0]];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  iob_wtb_mem u_dut_a (
    .clk_i(clk), .arst_n_i(arst_n), .iob_valid_i(valid), .iob_addr_i(addr),
    .iob_wdata_i(wdata), .iob_wstrb_i(wstrb), .iob_rdata_o(rdata_a),
    .iob_rvalid_o(rvalid_a), .iob_ready_o(ready_a), .invalidate_i(inv_i),
    .invalidate_o(inv_a), .wtb_empty_i(wte_i), .wtb_empty_o(wte_a),
    .wtb_level_o(level_a)
  );

  iob_wtb_mem #(.WTB_LOG2(1), .RD_LAT(3)) u_dut_b (
    .clk_i(clk), .arst_n_i(arst_n), .iob_valid_i(valid), .iob_addr_i(addr),
    .iob_wdata_i(wdata), .iob_wstrb_i(wstrb), .iob_rdata_o(rdata_b),
    .iob_rvalid_o(rvalid_b), .iob_ready_o(ready_b), .invalidate_i(inv_i),
    .invalidate_o(inv_b), .wtb_empty_i(wte_i), .wtb_empty_o(wte_b),
    .wtb_level_o(level_b)
  );

  // Scoreboard monitor: every rvalid pops one expectation (data and cycle).
  always @(negedge clk) begin
    exp_t e;
    if (arst_n) begin
      if (rvalid_a) begin
        checks++;
        if (qa.size() == 0) begin
          errors++;
          $display("FAIL sb_a_spurious rvalid at cyc %0d, none expected", cyc);
        end else begin
          e = qa.pop_front();
          if (rdata_a !== e.data || cyc != e.cyc) begin
            errors++;
            $display("FAIL sb_a got %h @%0d exp %h @%0d", rdata_a, cyc, e.data, e.cyc);
          end
        end
      end
      if (rvalid_b) begin
        checks++;
        if (qb.size() == 0) begin
          errors++;
          $display("FAIL sb_b_spurious rvalid at cyc %0d, none expected", cyc);
        end else begin
          e = qb.pop_front();
          if (rdata_b !== e.data || cyc != e.cyc) begin
            errors++;
            $display("FAIL sb_b got %h @%0d exp %h @%0d", rdata_b, cyc, e.data, e.cyc);
          end
        end
      end
    end
  end

  // One request; called right after a negedge, returns at the negedge after accept.
  task automatic req(input logic [18:0] a, input logic [255:0] d, input logic [31:0] s,
                     input bit upd, output int waited);
    logic [255:0] m;
    exp_t         e;
    valid = 1'b1; addr = a; wdata = d; wstrb = s; waited = 0;
    #1;
    while (!ready_a && waited < 20) begin
      @(negedge clk); #1;
      waited++;
    end
    if (!ready_a) begin
      checks++; errors++;
      $display("FAIL req_timeout addr %h ready 0 exp 1", a);
      @(negedge clk);
      valid = 1'b0;
      return;
    end
    checks++;
    if (ready_b !== 1'b1) begin
      errors++;
      $display("FAIL ready_b got %b exp 1 (addr %h)", ready_b, a);
    end
    if (s != 0) begin
      if (upd) begin
        m = model_mem.exists(a[9:0]) ? model_mem[a[9:0]] : '0;
        for (int b = 0; b < 32; b++) if (s[b]) m[b*8 +: 8] = d[b*8 +: 8];
        model_mem[a[9:0]] = m;
      end
    end else begin
      e.data = model_mem.exists(a[9:0]) ? model_mem[a[9:0]] : '0;
      e.cyc  = cyc + 1;
      qa.push_back(e);
      e.cyc  = cyc + 3;
      qb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL idle_timeout pending a %0d b %0d exp 0", qa.size(), qb.size());
      qa.delete(); qb.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    checks++;
    if (rdata_a !== '0 || rvalid_a !== 1'b0 || level_a !== 3'd0 || ready_a !== 1'b1) begin
      errors++;
      $display("FAIL reset_a rdata %h rvalid %b level %0d ready %b exp 0 0 0 1",
               rdata_a, rvalid_a, level_a, ready_a);
    end
    checks++;
    if (rdata_b !== '0 || rvalid_b !== 1'b0 || level_b !== 2'd0) begin
      errors++;
      $display("FAIL reset_b rdata %h rvalid %b level %0d exp 0 0 0", rdata_b, rvalid_b, level_b);
    end
    wte_i = 1'b0; #1;
    checks++;
    if (wte_a !== 1'b0 || wte_b !== 1'b0) begin
      errors++;
      $display("FAIL wte_low got %b %b exp 0 0", wte_a, wte_b);
    end
    wte_i = 1'b1; #1;
    checks++;
    if (wte_a !== 1'b1 || wte_b !== 1'b1) begin
      errors++;
      $display("FAIL wte_high got %b %b exp 1 1", wte_a, wte_b);
    end
    @(negedge clk); arst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    int w;
    req(19'h5, {8{32'h1234_5601}}, 32'hFFFF_FFFF, 1'b1, w);
    checks++;
    if (level_a !== 3'd1 || level_b !== 2'd1) begin
      errors++;
      $display("FAIL level_after_write got %0d %0d exp 1 1", level_a, level_b);
    end
    req(19'h5, '0, 32'h0, 1'b1, w);
    wait_idle();
  endtask

  task automatic test_strobe();
    int w;
    req(19'h6, {256{1'b1}}, 32'hFFFF_FFFF, 1'b1, w);
    req(19'h6, '0, 32'h0000_000F, 1'b1, w);
    req(19'h6, '0, 32'h0, 1'b1, w);
    wait_idle();
    checks++;
    if (rdata_a !== {{224{1'b1}}, 32'h0} || rdata_b !== {{224{1'b1}}, 32'h0}) begin
      errors++;
      $display("FAIL strobe_merge got %h exp %h", rdata_a, {{224{1'b1}}, 32'h0});
    end
  endtask

  task automatic test_stream_writes();
    int w;
    int maxl = 0;
    for (int i = 0; i < 5; i++) begin
      req(19'h10 + 19'(i), {8{32'h3000_0000 + i}}, 32'hFFFF_FFFF, 1'b1, w);
      checks++;
      if (w != 0) begin
        errors++;
        $display("FAIL stream_ready write %0d stalled %0d cycles exp 0", i, w);
      end
      if (int'(level_a) > maxl) maxl = int'(level_a);
      if (int'(level_b) > maxl) maxl = int'(level_b);
    end
    checks++;
    if (maxl > 2) begin
      errors++;
      $display("FAIL stream_level max %0d exp <= 2", maxl);
    end
    checks++;
    if (wte_a !== 1'b0 || wte_b !== 1'b0) begin
      errors++;
      $display("FAIL wte_busy got %b %b exp 0 0", wte_a, wte_b);
    end
    @(negedge clk);
    checks++;
    if (wte_a !== 1'b1 || wte_b !== 1'b1) begin
      errors++;
      $display("FAIL wte_drained got %b %b exp 1 1", wte_a, wte_b);
    end
    req(19'h14, '0, 32'h0, 1'b1, w);
    wait_idle();
  endtask

  task automatic test_read_after_write();
    int w;
    req(19'h7, {8{32'hCAFE_0007}}, 32'hFFFF_FFFF, 1'b1, w);
    req(19'h7, '0, 32'h0, 1'b1, w);
    checks++;
    if (w != 1) begin
      errors++;
      $display("FAIL raw_stall got %0d cycles exp 1", w);
    end
    wait_idle();
    checks++;
    if (rdata_a !== {8{32'hCAFE_0007}} || rdata_b !== {8{32'hCAFE_0007}}) begin
      errors++;
      $display("FAIL raw_data got %h exp %h", rdata_a, {8{32'hCAFE_0007}});
    end
  endtask

  task automatic test_back_to_back();
    int w;
    for (int i = 0; i < 3; i++) begin
      req(19'h5 + 19'(i), '0, 32'h0, 1'b1, w);
      checks++;
      if (w != 0) begin
        errors++;
        $display("FAIL b2b_read %0d stalled %0d exp 0", i, w);
      end
    end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int w;
    req(19'h20, {8{32'hAAAA_0020}}, 32'hFFFF_FFFF, 1'b1, w);
    req(19'h21, {8{32'hAAAA_0021}}, 32'hFFFF_FFFF, 1'b1, w);
    @(negedge clk); @(negedge clk);
    req(19'h20, {8{32'hBBBB_0020}}, 32'hFFFF_FFFF, 1'b0, w);
    req(19'h21, {8{32'hBBBB_0021}}, 32'hFFFF_FFFF, 1'b0, w);
    // First posted write has drained, second is still queued.
    model_mem[10'h20] = {8{32'hBBBB_0020}};
    arst_n = 1'b0; #1;
    checks++;
    if (level_a !== 3'd0 || level_b !== 2'd0 || rvalid_a !== 1'b0 || rvalid_b !== 1'b0
        || rdata_a !== '0 || rdata_b !== '0) begin
      errors++;
      $display("FAIL async_reset level %0d %0d rvalid %b %b rdata_a %h exp all 0",
               level_a, level_b, rvalid_a, rvalid_b, rdata_a);
    end
    checks++;
    if (wte_a !== wte_i || wte_b !== wte_i) begin
      errors++;
      $display("FAIL reset_wte got %b %b exp %b", wte_a, wte_b, wte_i);
    end
    @(negedge clk); arst_n = 1'b1;
    @(negedge clk);
    req(19'h20, '0, 32'h0, 1'b1, w);
    req(19'h21, '0, 32'h0, 1'b1, w);
    wait_idle();
    checks++;
    if (rdata_a !== {8{32'hAAAA_0021}}) begin
      errors++;
      $display("FAIL reset_drop got %h exp %h", rdata_a, {8{32'hAAAA_0021}});
    end
  endtask

  task automatic test_alias_invalidate();
    int w;
    req(19'h00005, {8{32'h7777_0005}}, 32'hFFFF_FFFF, 1'b1, w);
    req(19'h40005, '0, 32'h0, 1'b1, w);
    wait_idle();
    checks++;
    if (rdata_a !== {8{32'h7777_0005}}) begin
      errors++;
      $display("FAIL alias got %h exp %h", rdata_a, {8{32'h7777_0005}});
    end
    inv_i = 1'b1; #1;
    checks++;
    if (inv_a !== 1'b1 || inv_b !== 1'b1) begin
      errors++;
      $display("FAIL inv_high got %b %b exp 1 1", inv_a, inv_b);
    end
    inv_i = 1'b0; #1;
    checks++;
    if (inv_a !== 1'b0 || inv_b !== 1'b0) begin
      errors++;
      $display("FAIL inv_low got %b %b exp 0 0", inv_a, inv_b);
    end
  endtask

  initial begin
    arst_n = 1'b0; valid = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    inv_i = 1'b0; wte_i = 1'b1;
    test_reset();
    test_write_read();
    test_strobe();
    test_stream_writes();
    test_read_after_write();
    test_back_to_back();
    test_reset_mid();
    test_alias_invalidate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached, run incomplete");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
